// File: rtl/i2c_txn_arbiter.sv
`default_nettype none
// ============================================================================
// Module : i2c_txn_arbiter
// Round-robin sharing of one i2c_master with NACK retry and per-attempt watchdog.
// Rev    : 1.0  initial release
// ============================================================================
module i2c_txn_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int MAX_RETRY   = 2,
    parameter int TIMEOUT_CYC = 200000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [7*NUM_REQ-1:0] req_addr,
    input  logic [NUM_REQ-1:0]   req_rw,
    input  logic [8*NUM_REQ-1:0] req_wdata,
    output logic [NUM_REQ-1:0]   gnt,
    output logic [NUM_REQ-1:0]   done,
    output logic [7:0]           rdata,
    output logic [1:0]           err,
    output logic                 m_start,
    output logic [6:0]           m_addr,
    output logic                 m_rw,
    output logic [7:0]           m_data_in,
    input  logic [7:0]           m_data_out,
    input  logic                 m_ack_error,
    input  logic                 m_busy
);

    localparam int C_IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int C_TMR_W = $clog2(TIMEOUT_CYC + 1);
    localparam int C_RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [1:0]         C_ERR_OK   = 2'b00;
    localparam logic [1:0]         C_ERR_NACK = 2'b01;
    localparam logic [1:0]         C_ERR_TMO  = 2'b10;
    localparam logic [C_TMR_W-1:0] C_TMR_LAST = C_TMR_W'(TIMEOUT_CYC - 1);
    localparam logic [C_RTY_W-1:0] C_RTY_MAX  = C_RTY_W'(MAX_RETRY);
    localparam logic [C_IDX_W-1:0] C_IDX_LAST = C_IDX_W'(NUM_REQ - 1);
    localparam logic [NUM_REQ-1:0] C_ONE      = NUM_REQ'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_ISSUE = 3'd2,
        S_WAIT  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [C_IDX_W-1:0]   ptr_q, ptr_d, idx_q, idx_d;
    logic [C_RTY_W-1:0]   retry_q, retry_d;
    logic [C_TMR_W-1:0]   timer_q, timer_d;
    logic [1:0]           settle_q, settle_d;
    logic                 busy_s1_q, busy_s2_q, ack_s1_q, ack_s2_q;
    logic [NUM_REQ-1:0]   gnt_q, gnt_d, done_q, done_d;
    logic [7:0]           rdata_q, rdata_d, m_data_q, m_data_d;
    logic [1:0]           err_q, err_d;
    logic                 m_start_q, m_start_d, m_rw_q, m_rw_d;
    logic [6:0]           m_addr_q, m_addr_d;

    logic                 arb_found;
    logic [C_IDX_W-1:0]   arb_idx;
    logic [6:0]           sel_addr;
    logic                 sel_rw;
    logic [7:0]           sel_wdata;
    logic                 to_done;
    logic [1:0]           done_err;

    // First request at or after the pointer, wrapping around.
    always_comb begin
        int cand;
        arb_found = 1'b0;
        arb_idx   = '0;
        cand      = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = int'(ptr_q) + k;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
            if (!arb_found && req[cand[C_IDX_W-1:0]]) begin
                arb_found = 1'b1;
                arb_idx   = cand[C_IDX_W-1:0];
            end
        end
    end

    always_comb begin
        sel_addr  = '0;
        sel_rw    = 1'b0;
        sel_wdata = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (idx_q == C_IDX_W'(k)) begin
                sel_addr  = req_addr[7*k +: 7];
                sel_rw    = req_rw[k];
                sel_wdata = req_wdata[8*k +: 8];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        idx_d     = idx_q;
        retry_d   = retry_q;
        timer_d   = timer_q;
        settle_d  = settle_q;
        gnt_d     = gnt_q;
        done_d    = '0;
        rdata_d   = '0;
        err_d     = '0;
        m_start_d = m_start_q;
        m_addr_d  = m_addr_q;
        m_rw_d    = m_rw_q;
        m_data_d  = m_data_q;
        to_done   = 1'b0;
        done_err  = C_ERR_OK;

        case (state_q)
            // A timed-out master may still be busy; wait for it before granting again.
            S_IDLE: begin
                if (arb_found && !busy_s2_q) begin
                    idx_d   = arb_idx;
                    gnt_d   = C_ONE << arb_idx;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                m_addr_d  = sel_addr;
                m_rw_d    = sel_rw;
                m_data_d  = sel_wdata;
                timer_d   = '0;
                settle_d  = '0;
                m_start_d = 1'b1;
                state_d   = S_ISSUE;
            end
            S_ISSUE: begin
                timer_d = timer_q + 1'b1;
                if (timer_q == C_TMR_LAST) begin
                    to_done  = 1'b1;
                    done_err = C_ERR_TMO;
                end else if (busy_s2_q) begin
                    m_start_d = 1'b0;
                    state_d   = S_WAIT;
                end
            end
            S_WAIT: begin
                timer_d = timer_q + 1'b1;
                if (timer_q == C_TMR_LAST) begin
                    to_done  = 1'b1;
                    done_err = C_ERR_TMO;
                end else if (busy_s2_q) begin
                    settle_d = '0;
                end else if (settle_q == 2'd2) begin
                    if (ack_s2_q && retry_q < C_RTY_MAX) begin
                        retry_d = retry_q + 1'b1;
                        state_d = S_LOAD;
                    end else begin
                        to_done  = 1'b1;
                        done_err = ack_s2_q ? C_ERR_NACK : C_ERR_OK;
                    end
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end
            S_DONE: begin
                ptr_d   = (idx_q == C_IDX_LAST) ? '0 : idx_q + 1'b1;
                retry_d = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (to_done) begin
            done_d    = gnt_q;
            gnt_d     = '0;
            err_d     = done_err;
            rdata_d   = m_rw_q ? m_data_out : 8'h00;
            m_start_d = 1'b0;
            state_d   = S_DONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            ptr_q     <= '0;
            idx_q     <= '0;
            retry_q   <= '0;
            timer_q   <= '0;
            settle_q  <= '0;
            busy_s1_q <= 1'b0;
            busy_s2_q <= 1'b0;
            ack_s1_q  <= 1'b0;
            ack_s2_q  <= 1'b0;
            gnt_q     <= '0;
            done_q    <= '0;
            rdata_q   <= '0;
            err_q     <= '0;
            m_start_q <= 1'b0;
            m_addr_q  <= '0;
            m_rw_q    <= 1'b0;
            m_data_q  <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            idx_q     <= idx_d;
            retry_q   <= retry_d;
            timer_q   <= timer_d;
            settle_q  <= settle_d;
            busy_s1_q <= m_busy;
            busy_s2_q <= busy_s1_q;
            ack_s1_q  <= m_ack_error;
            ack_s2_q  <= ack_s1_q;
            gnt_q     <= gnt_d;
            done_q    <= done_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            m_start_q <= m_start_d;
            m_addr_q  <= m_addr_d;
            m_rw_q    <= m_rw_d;
            m_data_q  <= m_data_d;
        end
    end

    assign gnt       = gnt_q;
    assign done      = done_q;
    assign rdata     = rdata_q;
    assign err       = err_q;
    assign m_start   = m_start_q;
    assign m_addr    = m_addr_q;
    assign m_rw      = m_rw_q;
    assign m_data_in = m_data_q;

endmodule
`default_nettype wire

// File: doc/i2c_txn_arbiter.md
Name: i2c_txn_arbiter

Overview:
- Shares one i2c_master between NUM_REQ requesters (sensor pollers, config loaders) using round-robin arbitration.
- Sequences each transaction: loads addr/rw/data into the master, handshakes start against busy, and waits for completion.
- Retries NACKed transactions and enforces a watchdog timeout.
- Returns data_out and error status to the granted requester with a one-cycle done pulse.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- MAX_RETRY, 2, extra attempts after ack_error before reporting failure.
- TIMEOUT_CYC, 200000, clk cycles allowed per attempt (ISSUE+WAIT) before abort.

Ports:
- clk  input  1  system clock (100 MHz), same as i2c_master.
- rst_n  input  1  asynchronous active-low reset.
- req  input  NUM_REQ  per-requester request level.
- req_addr  input  7*NUM_REQ  7-bit slave address per requester; requester i uses bits [7i+6:7i].
- req_rw  input  NUM_REQ  0=write, 1=read.
- req_wdata  input  8*NUM_REQ  write byte per requester.
- gnt  output  NUM_REQ  one-hot; high while requester's transaction is owned.
- done  output  NUM_REQ  one-cycle pulse at completion, one-hot.
- rdata  output  8  read byte; valid in the done cycle.
- err  output  2  valid with done: 00 ok, 01 NACK after retries, 10 timeout.
- m_start  output  1  to i2c_master start.
- m_addr  output  7  to i2c_master addr.
- m_rw  output  1  to i2c_master rw.
- m_data_in  output  8  to i2c_master data_in.
- m_data_out  input  8  from i2c_master data_out.
- m_ack_error  input  1  from i2c_master ack_error.
- m_busy  input  1  from i2c_master busy (slow-clock domain).

Behaviour:
- Reset (async, rst_n=0):
  - all outputs 0; state IDLE; rr pointer=0; retry count=0; timer=0.
  - Reset mid-transaction drops m_start immediately; no done is issued.
- Synchronisation: m_busy and m_ack_error pass through 2-flop synchronisers. Internal "busy" below means the synchronised m_busy.
- States:
  - IDLE: if any req, pick the first set bit at or after the rr pointer (wrapping) -> LOAD. Arbitration takes 1 cycle.
  - LOAD:
    - Latch that requester's addr/rw/wdata into m_addr/m_rw/m_data_in; these hold stable until DONE.
    - Assert gnt[i]; clear timer -> ISSUE.
  - ISSUE:
    - m_start=1 until busy seen high, then m_start=0 -> WAIT.
    - The master samples start only on its slow clock, so start is held for up to ~2*DIVIDER clk cycles.
  - WAIT: stay while busy=1. On busy falling edge, hold 2 cycles to let data_out/ack_error settle, then:
    - if ack_error=1 and retry<MAX_RETRY: retry++ -> LOAD (same requester, gnt kept).
    - else -> DONE.
  - DONE:
    - done[i]=1 for 1 cycle; rdata=m_data_out when rw=1, else 0x00; err set.
    - gnt[i]=0; rr pointer=i+1 mod NUM_REQ; retry=0 -> IDLE.
- Timeout: the timer counts in ISSUE and WAIT. When timer==TIMEOUT_CYC-1: drop m_start, err=10 -> DONE. There is no retry on timeout.
- Timeout while busy is still high: DONE is reached, but IDLE does not grant until busy=0.
- Request rules:
  - Requester holds req and its fields stable until its done.
  - req dropping after LOAD is ignored; the transaction finishes and done still pulses.
  - A req held high after done re-enters arbitration next cycle at lowest priority.
- Timing and ordering:
  - Simultaneous new requests in the done cycle are not seen until IDLE.
  - At most one gnt and one done bit high at any time.
  - Latency from req to m_start is 3 cycles when IDLE and the pointer favours the requester.

Test Plan:
- Single write:
  - Stimulus: req[0]=1, addr 0x50, rw=0, wdata 0xA5; slave ACKs.
  - Required: m_start within 3 cycles; one done[0] pulse; err=00; gnt[0] high throughout.
- Read:
  - Stimulus: req[2], addr 0x48, rw=1; slave returns 0x3C.
  - Required: rdata=0x3C in the done[2] cycle; err=00.
- Round-robin:
  - Stimulus: req=4'b1111 held, all ACK.
  - Required: done order 0,1,2,3,0; no requester granted twice consecutively while others pend.
- NACK retry:
  - Stimulus: slave NACKs every attempt.
  - Required: exactly 3 m_start assertions (1+MAX_RETRY); one done; err=01.
  - Variant: NACK once then ACK -> err=00 after 2 starts.
- Timeout:
  - Stimulus: m_busy forced high forever.
  - Required: done with err=10 after TIMEOUT_CYC cycles; no new grant until busy released.
- Reset mid-WAIT:
  - Stimulus: pulse rst_n low during WAIT.
  - Required: all outputs 0 immediately; no done; after release, a pending req is re-arbitrated from pointer 0.
